// File: rtl/imem_responder.sv
// Multi-cycle memory responder for the Rd/Wr/Done/Stall fetch protocol with programmable latency.
// Optional one-entry read hit buffer enabled by defining IMEM_HIT_BUFFER_EN.
module imem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [15:0]            r_wdata;
  logic                   r_op_wr;
  logic [15:0]            r_dout;
  logic                   r_done;
  logic                   r_stall;
  logic                   r_cache_hit;
  logic                   r_err;
  logic [15:0]            r_mem [0:DEPTH-1];

  logic                   w_req;
  logic                   w_req_err;
  logic [ADDR_BITS-1:0]   w_req_addr;
  logic                   w_accept;
  logic                   w_hit;
  logic                   w_take_hit;
  logic                   w_fast;
  logic                   w_busy_done;
  logic                   w_commit;
  logic                   w_c_wr;
  logic [ADDR_BITS-1:0]   w_c_addr;
  logic [15:0]            w_c_wdata;
  logic [15:0]            w_c_rdata;
  logic                   w_mem_we;
  logic                   w_unused_addr;

  assign w_req      = Rd | Wr;
  assign w_req_err  = (Rd & Wr) | Addr[0];
  assign w_req_addr = Addr[ADDR_BITS:1];
  assign w_unused_addr = &{1'b0, Addr[15:ADDR_BITS+1]};

  assign w_accept    = w_req & ((r_state == IDLE) | (r_state == RESP));
  assign w_take_hit  = w_accept & w_hit;
  assign w_fast      = w_accept & ~w_req_err & ((LATENCY == 1) | w_hit);
  assign w_busy_done = (r_state == BUSY) & (r_cnt == 4'd1);

  // A request completes either out of BUSY (latched operands) or straight from acceptance.
  assign w_commit  = w_busy_done | w_fast;
  assign w_c_wr    = w_busy_done ? r_op_wr : Wr;
  assign w_c_addr  = w_busy_done ? r_addr  : w_req_addr;
  assign w_c_wdata = w_busy_done ? r_wdata : DataIn;
  // Gated by rst so a write cannot land while reset is held.
  assign w_mem_we  = rst & w_commit & w_c_wr;

`ifdef IMEM_HIT_BUFFER_EN
  logic                 r_hb_valid;
  logic [ADDR_BITS-1:0] r_hb_addr;
  logic [15:0]          r_hb_data;

  assign w_hit     = Rd & ~Wr & ~Addr[0] & r_hb_valid & (r_hb_addr == w_req_addr);
  assign w_c_rdata = w_take_hit ? r_hb_data : r_mem[w_c_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hb_valid <= 1'b0;
      r_hb_addr  <= '0;
      r_hb_data  <= '0;
    end else if (w_commit && !w_c_wr) begin
      r_hb_valid <= 1'b1;
      r_hb_addr  <= w_c_addr;
      r_hb_data  <= w_c_rdata;
    end else if (w_mem_we && r_hb_valid && (r_hb_addr == w_c_addr)) begin
      r_hb_data  <= w_c_wdata;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_c_rdata = r_mem[w_c_addr];
`endif

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_c_addr] <= w_c_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op_wr     <= 1'b0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_stall     <= 1'b0;
      r_cache_hit <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_stall     <= 1'b0;
      r_cache_hit <= 1'b0;
      r_err       <= 1'b0;
      r_dout      <= '0;
      case (r_state)
        IDLE, RESP: begin
          if (w_req) begin
            r_addr  <= w_req_addr;
            r_wdata <= DataIn;
            r_op_wr <= Wr;
            if (w_req_err) begin
              r_state <= RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (w_fast) begin
              r_state     <= RESP;
              r_done      <= 1'b1;
              r_cache_hit <= w_take_hit;
              r_dout      <= Wr ? 16'h0000 : w_c_rdata;
            end else begin
              r_state <= BUSY;
              r_cnt   <= LAT_M1;
              r_stall <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_dout  <= r_op_wr ? 16'h0000 : w_c_rdata;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
            r_stall <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DataOut  = r_dout;
  assign Done     = r_done;
  assign Stall    = r_stall;
  assign CacheHit = r_cache_hit;
  assign err      = r_err;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: driver pushes predicted responses, monitor checks each Done.
// Prediction follows IMEM_HIT_BUFFER_EN when the bench is built with it.
module tb_imem_responder;
  localparam int LAT = 4;
  localparam int AB  = 10;
`ifdef IMEM_HIT_BUFFER_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] DataIn = '0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;

  imem_responder #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        err;
    logic        hit;
    logic [15:0] data;
    int          stall;
  } exp_t;
  exp_t q[$];

  logic [15:0] ref_mem [0:1023];
  bit          hb_v = 1'b0;
  int          hb_a = 0;
  logic [15:0] hb_d = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Must be called right after a negedge; the request is accepted at the next posedge.
  task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d, input int gap);
    exp_t e;
    int   w;
    bit   bad, hit, seen;
    w    = (int'(a) / 2) % 1024;
    bad  = (rd && wr) || a[0];
    hit  = HB && hb_v && (hb_a == w) && rd && !wr && !bad;
    e.err = bad; e.hit = hit; e.data = 16'h0000; e.stall = 0;
    if (bad) begin
      e.due = cyc + 1;
    end else if (wr) begin
      ref_mem[w] = d;
      if (hb_v && hb_a == w) hb_d = d;
      e.due = cyc + LAT; e.stall = LAT - 1;
    end else begin
      e.data = ref_mem[w];
      e.due  = hit ? cyc + 1 : cyc + LAT;
      e.stall = hit ? 0 : LAT - 1;
      hb_v = 1'b1; hb_a = w; hb_d = ref_mem[w];
    end
    q.push_back(e);
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no Done expected Done for addr %h", a);
    end
    if (gap > 0) begin
      Rd = 1'b0; Wr = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  int stall_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      stall_run = 0;
    end else if (Done) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got Done=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("done_cycle", cyc, e.due);
        check("err", {31'b0, err}, {31'b0, e.err});
        check("data_out", {16'b0, DataOut}, {16'b0, e.data});
        check("cache_hit", {31'b0, CacheHit}, {31'b0, e.hit});
        check("stall_cycles", stall_run, e.stall);
        check("stall_at_done", {31'b0, Stall}, 32'd0);
      end
      stall_run = 0;
    end else begin
      if (Stall) stall_run++;
      check("quiet_outputs", {14'b0, DataOut, err, CacheHit}, 32'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    bit rd, wr;
    int r, w, gap;

    // Reset held with a read pending
    Rd = 1'b1; Addr = 16'h0010;
    repeat (4) begin
      @(negedge clk);
      check("reset_outputs", {11'b0, Done, Stall, CacheHit, err, DataOut}, 32'd0);
    end
    Rd = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {11'b0, Done, Stall, CacheHit, err, DataOut}, 32'd0);

    for (int i = 0; i < 64; i++) req(1'b0, 1'b1, 16'(i * 2), 16'($urandom), 1);

    req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1);
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1);

    // Back-to-back chain including read-after-write
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
    req(1'b1, 1'b0, 16'h0012, 16'h0000, 0);
    req(1'b0, 1'b1, 16'h0014, 16'hA5A5, 0);
    req(1'b1, 1'b0, 16'h0014, 16'h0000, 2);

    req(1'b1, 1'b0, 16'h0003, 16'h0000, 1);
    req(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 1);

    req(1'b0, 1'b1, 16'h0800, 16'h1234, 1);
    req(1'b1, 1'b0, 16'h0000, 16'h0000, 1);

    // Abort a write in BUSY with reset
    Wr = 1'b1; Addr = 16'h0040; DataIn = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_stall", {31'b0, Stall}, 32'd1);
    rst = 1'b0; Wr = 1'b0;
    #1;
    check("abort_outputs", {11'b0, Done, Stall, CacheHit, err, DataOut}, 32'd0);
    repeat (LAT + 2) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, Done}, 32'd0);
    end
    rst = 1'b1; hb_v = 1'b0;
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0040, 16'h0000, 1);

    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1);
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1);
    req(1'b0, 1'b1, 16'h0010, 16'hCAFE, 1);
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 63);
      a = 16'(($urandom & 32'h0000F800) | (w << 1));
      if (r == 0) begin
        rd = 1'b1; wr = 1'b1;
      end else if (r == 1) begin
        rd = 1'($urandom_range(0, 1)); wr = !rd; a[0] = 1'b1;
      end else begin
        rd = 1'($urandom_range(0, 1)); wr = !rd;
      end
      gap = (i == 149) ? 2 : $urandom_range(0, 2);
      req(rd, wr, a, 16'($urandom), gap);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
